// File: rtl/flag_pkg.sv
// Shared constants and the per-cycle operation encoding for the flag stack.
// Optional feature macro: FLAG_STACK_WRAP_EN (circular storage, overwrite oldest on full push).
package flag_pkg;

  localparam int unsigned NFLAGS_DEF = 2;
  localparam int unsigned DEPTH_DEF  = 4;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_LOAD,
    OP_PUSH,
    OP_POP,
    OP_XCHG
  } op_t;

endpackage

// File: rtl/flag_lifo.sv
// Flag word storage with count (and top pointer when wrapping).
// Macro FLAG_STACK_WRAP_EN: defined -> circular buffer, a full push overwrites
// the oldest entry; undefined -> linear LIFO indexed by count, full push dropped.
module flag_lifo
  import flag_pkg::*;
#(
  parameter int unsigned NFLAGS = NFLAGS_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       notReset,
  input  op_t                        op,
  input  logic [NFLAGS-1:0]          wdata,
  output logic [NFLAGS-1:0]          rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [NFLAGS-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_idx;
  logic [PW-1:0]     wr_idx;
  logic              wr_en;
  logic [CW-1:0]     count_next;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_idx];

`ifdef FLAG_STACK_WRAP_EN
  logic [PW-1:0] top_ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;

  assign ptr_inc = (top_ptr == PW'(DEPTH - 1)) ? '0 : top_ptr + 1'b1;
  assign ptr_dec = (top_ptr == '0) ? PW'(DEPTH - 1) : top_ptr - 1'b1;

  // Next pointer/count and write port; a full push lands on the oldest slot.
  always_comb begin
    ptr_next   = top_ptr;
    count_next = count;
    wr_en      = 1'b0;
    wr_idx     = top_ptr;
    rd_idx     = top_ptr;
    case (op)
      OP_PUSH: begin
        ptr_next = ptr_inc;
        wr_en    = 1'b1;
        wr_idx   = ptr_inc;
        if (!full) count_next = count + 1'b1;
      end
      OP_POP: begin
        if (!empty) begin
          ptr_next   = ptr_dec;
          count_next = count - 1'b1;
        end
      end
      OP_XCHG: begin
        if (!empty) wr_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Top pointer register; first push after reset lands in slot 0.
  always_ff @(posedge clk) begin
    if (!notReset) top_ptr <= PW'(DEPTH - 1);
    else           top_ptr <= ptr_next;
  end
`else
  // Next count and write port for the linear stack; top lives at count-1.
  always_comb begin
    count_next = count;
    wr_en      = 1'b0;
    rd_idx     = PW'(count - 1'b1);
    wr_idx     = rd_idx;
    case (op)
      OP_PUSH: begin
        if (!full) begin
          wr_en      = 1'b1;
          wr_idx     = PW'(count);
          count_next = count + 1'b1;
        end
      end
      OP_POP: begin
        if (!empty) count_next = count - 1'b1;
      end
      OP_XCHG: begin
        if (!empty) wr_en = 1'b1;
      end
      default: ;
    endcase
  end
`endif

  // Entry count register.
  always_ff @(posedge clk) begin
    if (!notReset) count <= '0;
    else           count <= count_next;
  end

  // Storage array; not reset, writes suppressed during reset.
  always_ff @(posedge clk) begin
    if (notReset && wr_en) mem[wr_idx] <= wdata;
  end

endmodule

// File: rtl/flag_stack.sv
// Active-low flag register with a small save/restore stack and sticky errors.
// Macro FLAG_STACK_WRAP_EN: when defined a push on a full stack overwrites the
// oldest entry without error; otherwise it is dropped and overflowErr is set.
module flag_stack
  import flag_pkg::*;
#(
  parameter int unsigned NFLAGS = NFLAGS_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       notReset,
  input  logic [NFLAGS-1:0]          flagsIn,
  input  logic [NFLAGS-1:0]          notLoadMask,
  input  logic                       notPush,
  input  logic                       notPop,
  input  logic                       clearErr,
  output logic [NFLAGS-1:0]          flagsOut,
  output logic [$clog2(DEPTH+1)-1:0] depthCount,
  output logic                       full,
  output logic                       empty,
  output logic                       overflowErr,
  output logic                       underflowErr
);

  op_t               op;
  logic [NFLAGS-1:0] loaded;
  logic [NFLAGS-1:0] top;
  logic [NFLAGS-1:0] flags_next;
  logic              ovf_set;
  logic              unf_set;

  // One operation per cycle; a push carries the masked load with it.
  always_comb begin
    op = OP_NONE;
    if (!notPush && !notPop)     op = OP_XCHG;
    else if (!notPop)            op = OP_POP;
    else if (!notPush)           op = OP_PUSH;
    else if (notLoadMask != '1)  op = OP_LOAD;
  end

  assign loaded = (flagsOut & notLoadMask) | (flagsIn & ~notLoadMask);

  // Next flag word: failed pops still take the load, failed exchanges hold.
  always_comb begin
    flags_next = flagsOut;
    case (op)
      OP_LOAD, OP_PUSH: flags_next = loaded;
      OP_POP:           flags_next = empty ? loaded : top;
      OP_XCHG:          if (!empty) flags_next = top;
      default: ;
    endcase
  end

  // Error events for this cycle.
  always_comb begin
`ifdef FLAG_STACK_WRAP_EN
    ovf_set = 1'b0;
`else
    ovf_set = (op == OP_PUSH) && full;
`endif
    unf_set = ((op == OP_POP) || (op == OP_XCHG)) && empty;
  end

  // Flag word and sticky errors; a new error beats clearErr.
  always_ff @(posedge clk) begin
    if (!notReset) begin
      flagsOut     <= '1;
      overflowErr  <= 1'b0;
      underflowErr <= 1'b0;
    end else begin
      flagsOut     <= flags_next;
      overflowErr  <= ovf_set | (overflowErr  & ~clearErr);
      underflowErr <= unf_set | (underflowErr & ~clearErr);
    end
  end

  flag_lifo #(
    .NFLAGS (NFLAGS),
    .DEPTH  (DEPTH)
  ) u_lifo (
    .clk      (clk),
    .notReset (notReset),
    .op       (op),
    .wdata    (flagsOut),
    .rdata    (top),
    .count    (depthCount),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_flag_stack.sv
// Directed self-checking bench for flag_stack (NFLAGS=2, DEPTH=4).
// Expectations follow FLAG_STACK_WRAP_EN when it is defined for the build.
module tb_flag_stack;

  logic       clk = 1'b0;
  logic       notReset = 1'b0;
  logic [1:0] flagsIn = 2'b00;
  logic [1:0] notLoadMask = 2'b11;
  logic       notPush = 1'b1;
  logic       notPop = 1'b1;
  logic       clearErr = 1'b0;
  logic [1:0] flagsOut;
  logic [2:0] depthCount;
  logic       full, empty, overflowErr, underflowErr;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  flag_stack #(.NFLAGS(2), .DEPTH(4)) dut (
    .clk          (clk),
    .notReset     (notReset),
    .flagsIn      (flagsIn),
    .notLoadMask  (notLoadMask),
    .notPush      (notPush),
    .notPop       (notPop),
    .clearErr     (clearErr),
    .flagsOut     (flagsOut),
    .depthCount   (depthCount),
    .full         (full),
    .empty        (empty),
    .overflowErr  (overflowErr),
    .underflowErr (underflowErr)
  );

  always #5 clk = ~clk;

  // One clock edge, then return inputs to idle for the next vector.
  task automatic tick;
    @(posedge clk);
    #1;
    notReset    = 1'b1;
    notPush     = 1'b1;
    notPop      = 1'b1;
    notLoadMask = 2'b11;
    clearErr    = 1'b0;
  endtask

  task automatic do_reset;
    notReset = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    vectors++; if (flagsOut !== 2'b11) begin miscompares++; $display("FAIL rst_flags: got %b want 11", flagsOut); end
    vectors++; if (depthCount !== 3'd0) begin miscompares++; $display("FAIL rst_depth: got %0d want 0", depthCount); end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty: got %b want 1", empty); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL rst_full: got %b want 0", full); end
    vectors++; if (overflowErr !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %b want 0", overflowErr); end
    vectors++; if (underflowErr !== 1'b0) begin miscompares++; $display("FAIL rst_unf: got %b want 0", underflowErr); end
    tick();
    vectors++; if (flagsOut !== 2'b11 || depthCount !== 3'd0) begin miscompares++; $display("FAIL idle_hold: got %b/%0d want 11/0", flagsOut, depthCount); end
  endtask

  task automatic test_load_push_pop;
    do_reset();
    flagsIn = 2'b01; notLoadMask = 2'b00; tick();
    vectors++; if (flagsOut !== 2'b01) begin miscompares++; $display("FAIL lpp_load: got %b want 01", flagsOut); end
    notPush = 1'b0; tick();
    vectors++; if (depthCount !== 3'd1 || flagsOut !== 2'b01) begin miscompares++; $display("FAIL lpp_push: got %b/%0d want 01/1", flagsOut, depthCount); end
    flagsIn = 2'b10; notLoadMask = 2'b00; tick();
    vectors++; if (flagsOut !== 2'b10) begin miscompares++; $display("FAIL lpp_load2: got %b want 10", flagsOut); end
    notPop = 1'b0; flagsIn = 2'b00; notLoadMask = 2'b00; tick();
    vectors++; if (flagsOut !== 2'b01 || depthCount !== 3'd0) begin miscompares++; $display("FAIL lpp_pop: got %b/%0d want 01/0", flagsOut, depthCount); end
    vectors++; if (empty !== 1'b1 || underflowErr !== 1'b0) begin miscompares++; $display("FAIL lpp_state: empty %b unf %b want 1 0", empty, underflowErr); end
  endtask

  task automatic test_masked_load;
    do_reset();
    flagsIn = 2'b00; notLoadMask = 2'b10; tick();
    vectors++; if (flagsOut !== 2'b10) begin miscompares++; $display("FAIL mask_bit0: got %b want 10", flagsOut); end
    flagsIn = 2'b01; notLoadMask = 2'b01; tick();
    vectors++; if (flagsOut !== 2'b00) begin miscompares++; $display("FAIL mask_bit1: got %b want 00", flagsOut); end
  endtask

  task automatic test_fill;
    logic [1:0] vals [5];
    logic [1:0] exp_pop [4];
    logic       exp_ovf;
    vals = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
`ifdef FLAG_STACK_WRAP_EN
    exp_pop = '{2'b00, 2'b11, 2'b10, 2'b01};
    exp_ovf = 1'b0;
`else
    exp_pop = '{2'b11, 2'b10, 2'b01, 2'b00};
    exp_ovf = 1'b1;
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      flagsIn = vals[i]; notLoadMask = 2'b00; tick();
      notPush = 1'b0; tick();
      if (i == 3) begin
        vectors++; if (full !== 1'b1 || overflowErr !== 1'b0) begin miscompares++; $display("FAIL fill_full: full %b ovf %b want 1 0", full, overflowErr); end
      end
    end
    vectors++; if (depthCount !== 3'd4 || full !== 1'b1) begin miscompares++; $display("FAIL fill_depth: got %0d full %b want 4 1", depthCount, full); end
    vectors++; if (overflowErr !== exp_ovf) begin miscompares++; $display("FAIL fill_ovf: got %b want %b", overflowErr, exp_ovf); end
    for (int i = 0; i < 4; i++) begin
      notPop = 1'b0; tick();
      vectors++; if (flagsOut !== exp_pop[i] || depthCount !== 3'(3 - i)) begin
        miscompares++; $display("FAIL fill_pop%0d: got %b/%0d want %b/%0d", i, flagsOut, depthCount, exp_pop[i], 3 - i);
      end
    end
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL fill_empty: got %b want 1", empty); end
    clearErr = 1'b1; tick();
    vectors++; if (overflowErr !== 1'b0) begin miscompares++; $display("FAIL fill_clr: got %b want 0", overflowErr); end
  endtask

  task automatic test_underflow_xchg;
    do_reset();
    notPop = 1'b0; tick();
    vectors++; if (underflowErr !== 1'b1 || flagsOut !== 2'b11 || depthCount !== 3'd0) begin
      miscompares++; $display("FAIL unf_pop: unf %b flags %b depth %0d want 1 11 0", underflowErr, flagsOut, depthCount);
    end
    notPop = 1'b0; flagsIn = 2'b00; notLoadMask = 2'b10; tick();
    vectors++; if (flagsOut !== 2'b10 || depthCount !== 3'd0) begin miscompares++; $display("FAIL unf_load: got %b/%0d want 10/0", flagsOut, depthCount); end
    clearErr = 1'b1; tick();
    vectors++; if (underflowErr !== 1'b0) begin miscompares++; $display("FAIL unf_clear: got %b want 0", underflowErr); end
    clearErr = 1'b1; notPop = 1'b0; tick();
    vectors++; if (underflowErr !== 1'b1) begin miscompares++; $display("FAIL unf_clr_race: got %b want 1", underflowErr); end
    clearErr = 1'b1; tick();
    notPush = 1'b0; notPop = 1'b0; flagsIn = 2'b01; notLoadMask = 2'b00; tick();
    vectors++; if (underflowErr !== 1'b1 || flagsOut !== 2'b10 || depthCount !== 3'd0) begin
      miscompares++; $display("FAIL xchg_empty: unf %b flags %b depth %0d want 1 10 0", underflowErr, flagsOut, depthCount);
    end
    clearErr = 1'b1; flagsIn = 2'b01; notLoadMask = 2'b00; tick();
    notPush = 1'b0; tick();
    flagsIn = 2'b10; notLoadMask = 2'b00; tick();
    notPush = 1'b0; notPop = 1'b0; flagsIn = 2'b11; notLoadMask = 2'b00; tick();
    vectors++; if (flagsOut !== 2'b01 || depthCount !== 3'd1 || underflowErr !== 1'b0) begin
      miscompares++; $display("FAIL xchg: flags %b depth %0d unf %b want 01 1 0", flagsOut, depthCount, underflowErr);
    end
    notPop = 1'b0; tick();
    vectors++; if (flagsOut !== 2'b10 || depthCount !== 3'd0) begin miscompares++; $display("FAIL xchg_pop: got %b/%0d want 10/0", flagsOut, depthCount); end
  endtask

  task automatic test_reset_push;
    do_reset();
    flagsIn = 2'b00; notLoadMask = 2'b00; tick();
    notReset = 1'b0; notPush = 1'b0; flagsIn = 2'b01; notLoadMask = 2'b00; tick();
    vectors++; if (depthCount !== 3'd0 || flagsOut !== 2'b11) begin miscompares++; $display("FAIL rst_push: got %b/%0d want 11/0", flagsOut, depthCount); end
    vectors++; if (empty !== 1'b1 || full !== 1'b0) begin miscompares++; $display("FAIL rst_push_flags: empty %b full %b want 1 0", empty, full); end
  endtask

  initial begin
    test_reset();
    test_load_push_pop();
    test_masked_load();
    test_fill();
    test_underflow_xchg();
    test_reset_push();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
